// File: rtl/mac_flow_ctrl.sv
// 802.3x flow-control scheduler: turns RX FIFO watermark crossings into XOFF/XON pause-frame
// requests for the TX MAC and holds off TX data frames while paused.
module mac_flow_ctrl #(
   parameter int unsigned FIFO_ADDR_WIDTH = 11,
   parameter int unsigned HIGH_WATERMARK  = 1536,
   parameter int unsigned LOW_WATERMARK   = 512,
   parameter logic [15:0] PAUSE_QUANTA    = 16'hFFFF,
   parameter int unsigned REFRESH_CYCLES  = 32768
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fc_enable,
   input  logic [FIFO_ADDR_WIDTH:0] rx_fifo_level,
   input  logic                     rx_pause_frame,
   output logic                     pause_req,
   output logic [15:0]              pause_quanta,
   input  logic                     pause_ack,
   output logic                     tx_data_hold,
   output logic                     xoff_active,
   output logic [15:0]              xoff_count
);

   localparam int unsigned LW = FIFO_ADDR_WIDTH + 1;
   localparam int unsigned CW = $clog2(REFRESH_CYCLES);

   localparam logic [LW-1:0] HIGH_LVL     = LW'(HIGH_WATERMARK);
   localparam logic [LW-1:0] LOW_LVL      = LW'(LOW_WATERMARK);
   localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_CYCLES - 1);

   typedef enum logic [1:0] {
      StXonIdle,
      StSendXoff,
      StPaused,
      StSendXon
   } state_t;

   state_t        state_q, state_d;
   logic          pause_req_q, pause_req_d;
   logic [15:0]   pause_quanta_q, pause_quanta_d;
   logic          tx_data_hold_q;
   logic          xoff_active_q, xoff_active_d;
   logic [15:0]   xoff_count_q, xoff_count_d;
   logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
   logic          rx_pause_q;
   logic          ack_ok;

   // An ack seen while no request is outstanding is stale and must not advance the FSM.
   assign ack_ok = pause_ack & pause_req_q;

   always_comb begin
      state_d        = state_q;
      pause_req_d    = pause_req_q;
      pause_quanta_d = pause_quanta_q;
      xoff_active_d  = xoff_active_q;
      xoff_count_d   = xoff_count_q;
      refresh_cnt_d  = refresh_cnt_q;

      unique case (state_q)
         StXonIdle: begin
            if (fc_enable && (rx_fifo_level >= HIGH_LVL)) begin
               state_d        = StSendXoff;
               pause_req_d    = 1'b1;
               pause_quanta_d = PAUSE_QUANTA;
            end
         end
         StSendXoff: begin
            if (ack_ok) begin
               state_d       = StPaused;
               pause_req_d   = 1'b0;
               xoff_active_d = 1'b1;
               refresh_cnt_d = '0;
               if (xoff_count_q != 16'hFFFF) begin
                  xoff_count_d = xoff_count_q + 16'd1;
               end
            end
         end
         StPaused: begin
            refresh_cnt_d = refresh_cnt_q + 1'b1;
            if (!fc_enable || (rx_fifo_level <= LOW_LVL)) begin
               state_d        = StSendXon;
               pause_req_d    = 1'b1;
               pause_quanta_d = 16'h0000;
            end else if (refresh_cnt_q == REFRESH_LAST) begin
               state_d        = StSendXoff;
               pause_req_d    = 1'b1;
               pause_quanta_d = PAUSE_QUANTA;
            end
         end
         StSendXon: begin
            if (ack_ok) begin
               state_d       = StXonIdle;
               pause_req_d   = 1'b0;
               xoff_active_d = 1'b0;
            end
         end
         default: begin
            state_d     = StXonIdle;
            pause_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= StXonIdle;
         pause_req_q    <= 1'b0;
         pause_quanta_q <= 16'h0000;
         tx_data_hold_q <= 1'b0;
         xoff_active_q  <= 1'b0;
         xoff_count_q   <= 16'h0000;
         refresh_cnt_q  <= '0;
         rx_pause_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         pause_req_q    <= pause_req_d;
         pause_quanta_q <= pause_quanta_d;
         tx_data_hold_q <= rx_pause_q | pause_req_d;
         xoff_active_q  <= xoff_active_d;
         xoff_count_q   <= xoff_count_d;
         refresh_cnt_q  <= refresh_cnt_d;
         rx_pause_q     <= rx_pause_frame;
      end
   end

   assign pause_req    = pause_req_q;
   assign pause_quanta = pause_quanta_q;
   assign tx_data_hold = tx_data_hold_q;
   assign xoff_active  = xoff_active_q;
   assign xoff_count   = xoff_count_q;

endmodule

// File: tb/tb_mac_flow_ctrl.sv
// Self-checking bench for mac_flow_ctrl; expected pause quanta are queued when a request is
// provoked and checked when the request edge appears.
module tb_mac_flow_ctrl;

   localparam int unsigned FAW = 11;

   logic          clk;
   logic          reset_n;
   logic          fc_enable;
   logic [FAW:0]  rx_fifo_level;
   logic          rx_pause_frame;
   logic          pause_req;
   logic [15:0]   pause_quanta;
   logic          pause_ack;
   logic          tx_data_hold;
   logic          xoff_active;
   logic [15:0]   xoff_count;

   int checks;
   int errors;
   logic [15:0] exp_q[$];
   logic prev_req;

   mac_flow_ctrl #(
      .FIFO_ADDR_WIDTH(FAW),
      .HIGH_WATERMARK (1536),
      .LOW_WATERMARK  (512),
      .PAUSE_QUANTA   (16'hFFFF),
      .REFRESH_CYCLES (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fc_enable     (fc_enable),
      .rx_fifo_level (rx_fifo_level),
      .rx_pause_frame(rx_pause_frame),
      .pause_req     (pause_req),
      .pause_quanta  (pause_quanta),
      .pause_ack     (pause_ack),
      .tx_data_hold  (tx_data_hold),
      .xoff_active   (xoff_active),
      .xoff_count    (xoff_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every rising pause_req must carry the quanta queued for it.
   initial prev_req = 1'b0;
   always @(negedge clk) begin
      if (pause_req === 1'b1 && prev_req !== 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_req quanta=%h required=no request", pause_quanta);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (pause_quanta !== e) begin
               errors++;
               $display("FAIL sb_quanta actual=%h required=%h", pause_quanta, e);
            end
         end
      end
      prev_req = pause_req;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ack();
      pause_ack = 1'b1;
      step();
      pause_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step();
      step();
      checks++;
      if ({pause_req, pause_quanta, tx_data_hold, xoff_active, xoff_count} !== 35'd0) begin
         errors++;
         $display("FAIL reset req=%b q=%h hold=%b xa=%b cnt=%h required all zero",
                  pause_req, pause_quanta, tx_data_hold, xoff_active, xoff_count);
      end
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_high_watermark();
      int bad;
      bad = 0;
      fc_enable     = 1'b1;
      rx_fifo_level = 12'd1535;
      for (int i = 0; i < 100; i++) begin
         step();
         if (pause_req !== 1'b0 || xoff_active !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL below_high bad_cycles=%0d required=0", bad);
      end
      rx_fifo_level = 12'd1536;
      exp_q.push_back(16'hFFFF);
      step();
      checks++;
      if (pause_req !== 1'b1 || tx_data_hold !== 1'b1) begin
         errors++;
         $display("FAIL at_high req=%b hold=%b required=1 1", pause_req, tx_data_hold);
      end
   endtask

   task automatic test_ack_wait();
      int bad;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (pause_req !== 1'b1 || pause_quanta !== 16'hFFFF) bad++;
         rx_fifo_level = 12'd100;
         step();
      end
      if (pause_req !== 1'b1 || pause_quanta !== 16'hFFFF) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL xoff_hold_stable bad_cycles=%0d required=0", bad);
      end
      rx_fifo_level = 12'd1000;
      exp_q.push_back(16'hFFFF);
      do_ack();
      checks++;
      if (pause_req !== 1'b0 || xoff_active !== 1'b1 || xoff_count !== 16'd1) begin
         errors++;
         $display("FAIL xoff_ack req=%b xa=%b cnt=%0d required=0 1 1",
                  pause_req, xoff_active, xoff_count);
      end
   endtask

   task automatic test_refresh();
      int edges;
      edges = 0;
      while (pause_req !== 1'b1 && edges < 100) begin
         step();
         edges++;
      end
      checks++;
      if (edges != 16) begin
         errors++;
         $display("FAIL refresh_delay edges=%0d required=16", edges);
      end
      checks++;
      if (xoff_active !== 1'b1) begin
         errors++;
         $display("FAIL refresh_xoff_active actual=%b required=1", xoff_active);
      end
      do_ack();
      checks++;
      if (xoff_count !== 16'd2 || pause_req !== 1'b0) begin
         errors++;
         $display("FAIL refresh_ack cnt=%0d req=%b required=2 0", xoff_count, pause_req);
      end
   endtask

   task automatic test_xon();
      rx_fifo_level = 12'd512;
      exp_q.push_back(16'h0000);
      step();
      checks++;
      if (pause_req !== 1'b1 || xoff_active !== 1'b1) begin
         errors++;
         $display("FAIL xon_req req=%b xa=%b required=1 1", pause_req, xoff_active);
      end
      do_ack();
      checks++;
      if (pause_req !== 1'b0 || xoff_active !== 1'b0) begin
         errors++;
         $display("FAIL xon_ack req=%b xa=%b required=0 0", pause_req, xoff_active);
      end
      rx_fifo_level = 12'd1000;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (pause_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_between actual=%b required=0", pause_req);
      end
   endtask

   task automatic test_xon_beats_refresh();
      int bad;
      bad = 0;
      rx_fifo_level = 12'd2000;
      exp_q.push_back(16'hFFFF);
      step();
      rx_fifo_level = 12'd1000;
      do_ack();
      for (int i = 0; i < 15; i++) begin
         step();
         if (pause_req !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL early_refresh bad_cycles=%0d required=0", bad);
      end
      rx_fifo_level = 12'd511;
      exp_q.push_back(16'h0000);
      step();
      checks++;
      if (pause_req !== 1'b1) begin
         errors++;
         $display("FAIL xon_wins req=%b required=1", pause_req);
      end
      do_ack();
      checks++;
      if (xoff_active !== 1'b0 || xoff_count !== 16'd3) begin
         errors++;
         $display("FAIL xon_wins_ack xa=%b cnt=%0d required=0 3", xoff_active, xoff_count);
      end
   endtask

   task automatic test_rx_pause();
      logic prev_rx;
      int   bad;
      int   highs;
      prev_rx       = 1'b0;
      bad           = 0;
      highs         = 0;
      fc_enable     = 1'b0;
      rx_fifo_level = 12'd2047;
      for (int i = 0; i < 16; i++) begin
         rx_pause_frame = (i < 10);
         step();
         if (tx_data_hold !== prev_rx || pause_req !== 1'b0) bad++;
         if (tx_data_hold === 1'b1) highs++;
         prev_rx = rx_pause_frame;
      end
      rx_pause_frame = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL rx_pause_hold bad_cycles=%0d required=0", bad);
      end
      checks++;
      if (highs != 10) begin
         errors++;
         $display("FAIL rx_pause_len actual=%0d required=10", highs);
      end
   endtask

   task automatic test_reset_mid_xoff();
      fc_enable     = 1'b1;
      rx_fifo_level = 12'd1536;
      exp_q.push_back(16'hFFFF);
      step();
      checks++;
      if (pause_req !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_req actual=%b required=1", pause_req);
      end
      reset_n = 1'b0;
      step();
      checks++;
      if ({pause_req, pause_quanta, tx_data_hold, xoff_active, xoff_count} !== 35'd0) begin
         errors++;
         $display("FAIL mid_reset req=%b q=%h hold=%b xa=%b cnt=%h required all zero",
                  pause_req, pause_quanta, tx_data_hold, xoff_active, xoff_count);
      end
      reset_n       = 1'b1;
      rx_fifo_level = 12'd0;
      do_ack();
      for (int i = 0; i < 20; i++) step();
      checks++;
      if (pause_req !== 1'b0 || xoff_active !== 1'b0 || xoff_count !== 16'd0) begin
         errors++;
         $display("FAIL late_ack req=%b xa=%b cnt=%0d required=0 0 0",
                  pause_req, xoff_active, xoff_count);
      end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      reset_n        = 1'b0;
      fc_enable      = 1'b0;
      rx_fifo_level  = '0;
      rx_pause_frame = 1'b0;
      pause_ack      = 1'b0;
      test_reset();
      test_high_watermark();
      test_ack_wait();
      test_refresh();
      test_xon();
      test_xon_beats_refresh();
      test_rx_pause();
      test_reset_mid_xoff();
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
